// File: rtl/write_request_queue_pkg.sv
// Shared front-end command types plus the write-queue flush FSM types and helpers.
package frontend_command_definition_pkg;
  localparam int BANK_W = 3;
  localparam int ROW_W  = 14;
  localparam int COL_W  = 10;
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;

  typedef struct packed {
    logic [1:0]        opcode;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [7:0]        tag;
  } frontend_command_t;

  typedef enum logic [1:0] {
    WRQ_IDLE, WRQ_FLUSH_RAW, WRQ_FLUSH_WM, WRQ_FLUSH_AGE
  } wrq_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE, CAUSE_RAW, CAUSE_WM, CAUSE_AGE
  } wrq_flush_cause_e;

  // State and its decoded outputs travel together so they always update on the same edge.
  typedef struct packed {
    wrq_state_e       state;
    logic             flush;
    wrq_flush_cause_e cause;
  } wrq_fsm_t;

  function automatic logic [ADDR_W-1:0] cmd_addr(input frontend_command_t c);
    return {c.bank, c.row, c.col};
  endfunction

  function automatic wrq_fsm_t wrq_go(input wrq_state_e s);
    wrq_fsm_t f;
    f.state = s;
    f.flush = (s != WRQ_IDLE);
    case (s)
      WRQ_FLUSH_RAW: f.cause = CAUSE_RAW;
      WRQ_FLUSH_WM:  f.cause = CAUSE_WM;
      WRQ_FLUSH_AGE: f.cause = CAUSE_AGE;
      default:       f.cause = CAUSE_NONE;
    endcase
    return f;
  endfunction
endpackage

// File: rtl/write_request_queue_if.sv
// Push/pop handshake bundle for the write request queue (producer = master).
interface write_request_queue_if;
  import frontend_command_definition_pkg::*;
  logic              wr_valid;
  logic              wr_ready;
  frontend_command_t wr_cmd;
  logic              cmd_valid;
  logic              cmd_ready;
  frontend_command_t cmd;

  modport master (output wr_valid, wr_cmd, cmd_ready, input wr_ready, cmd_valid, cmd);
  modport slave  (input wr_valid, wr_cmd, cmd_ready, output wr_ready, cmd_valid, cmd);
endinterface

// File: rtl/write_request_queue_addr_match.sv
// Parametrised CAM: one comparator per entry, gated by per-entry valid, OR-reduced to one hit.
module write_addr_match #(
  parameter int ENTRIES = 17,
  parameter int ADDR_W  = 27
) (
  input  logic [ENTRIES-1:0][ADDR_W-1:0] i_entry_addr,
  input  logic [ENTRIES-1:0]             i_entry_valid,
  input  logic                           i_probe_valid,
  input  logic [ADDR_W-1:0]              i_probe_addr,
  output logic                           o_hit
);
  logic [ENTRIES-1:0] w_match;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    assign w_match[g] = i_entry_valid[g] && (i_entry_addr[g] == i_probe_addr);
  end

  assign o_hit = i_probe_valid && (|w_match);
endmodule

// File: rtl/write_request_queue.sv
// Write request FIFO with read-after-write probe and flush control (RAW / watermark / age).
// Age-triggered flush is built only when WRQ_AGE_FLUSH_EN is defined.
module write_request_queue
  import frontend_command_definition_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int HI_WATERMARK = 12,
  parameter int LO_WATERMARK = 4,
  parameter int AGE_LIMIT    = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  frontend_command_t i_wr_cmd,
  input  logic              i_rd_probe_valid,
  input  logic [ADDR_W-1:0] i_rd_probe_addr,
  output logic              o_raw_hit,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output frontend_command_t o_cmd,
  output logic [DEPTH_LOG2:0] o_occupancy,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_flush,
  output wrq_flush_cause_e  o_flush_cause
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
  localparam logic [PW-1:0] HI_W    = PW'(HI_WATERMARK);
  localparam logic [PW-1:0] LO_W    = PW'(LO_WATERMARK);

  frontend_command_t r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_occ, r_raw_tail;
  logic          r_full, r_empty;
  wrq_fsm_t      r_fsm;

  logic          w_push, w_pop, w_raw_hit;
  logic [PW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_occ_nxt;

  assign w_push       = i_wr_valid && !r_full;
  assign w_pop        = !r_empty && i_cmd_ready;
  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);
  assign w_occ_nxt    = w_wr_ptr_nxt - w_rd_ptr_nxt;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wr_cmd;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_occ    <= w_occ_nxt;
      r_full   <= (w_occ_nxt == DEPTH_W);
      r_empty  <= (w_occ_nxt == '0);
    end
  end

  // CAM slot DEPTH carries the write being accepted this cycle.
  logic [DEPTH:0][ADDR_W-1:0] w_cam_addr;
  logic [DEPTH:0]             w_cam_vld;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [DEPTH_LOG2-1:0] w_off;
    assign w_off         = DEPTH_LOG2'(g) - r_rd_ptr[DEPTH_LOG2-1:0];
    assign w_cam_addr[g] = cmd_addr(r_mem[g]);
    assign w_cam_vld[g]  = ({1'b0, w_off} < r_occ);
  end
  assign w_cam_addr[DEPTH] = cmd_addr(i_wr_cmd);
  assign w_cam_vld[DEPTH]  = w_push;

  write_addr_match #(.ENTRIES(DEPTH + 1), .ADDR_W(ADDR_W)) u_match (
    .i_entry_addr (w_cam_addr),
    .i_entry_valid(w_cam_vld),
    .i_probe_valid(i_rd_probe_valid),
    .i_probe_addr (i_rd_probe_addr),
    .o_hit        (w_raw_hit)
  );

`ifdef WRQ_AGE_FLUSH_EN
  localparam int AGE_W = (AGE_LIMIT < 1) ? 1 : $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
  logic [AGE_W-1:0] r_age;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                r_age <= '0;
    else if (r_empty || w_pop)   r_age <= '0;
    else if (r_age != AGE_MAX)   r_age <= r_age + AGE_W'(1);
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm      <= wrq_go(WRQ_IDLE);
      r_raw_tail <= '0;
    end else if (w_raw_hit) begin
      r_fsm      <= wrq_go(WRQ_FLUSH_RAW);
      r_raw_tail <= w_wr_ptr_nxt;
    end else begin
      case (r_fsm.state)
        WRQ_IDLE: begin
          if (w_occ_nxt >= HI_W) r_fsm <= wrq_go(WRQ_FLUSH_WM);
`ifdef WRQ_AGE_FLUSH_EN
          else if (r_age == AGE_MAX) r_fsm <= wrq_go(WRQ_FLUSH_AGE);
`endif
        end
        WRQ_FLUSH_RAW: begin
          if (r_rd_ptr == r_raw_tail) begin
            if (r_occ >= HI_W) r_fsm <= wrq_go(WRQ_FLUSH_WM);
            else               r_fsm <= wrq_go(WRQ_IDLE);
          end
        end
        WRQ_FLUSH_WM: begin
          if (r_occ <= LO_W) r_fsm <= wrq_go(WRQ_IDLE);
        end
`ifdef WRQ_AGE_FLUSH_EN
        WRQ_FLUSH_AGE: begin
          if (w_occ_nxt >= HI_W)      r_fsm <= wrq_go(WRQ_FLUSH_WM);
          else if (w_occ_nxt == '0)   r_fsm <= wrq_go(WRQ_IDLE);
        end
`endif
        default: r_fsm <= wrq_go(WRQ_IDLE);
      endcase
    end
  end

  assign o_wr_ready    = !r_full;
  assign o_cmd_valid   = !r_empty;
  assign o_cmd         = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign o_raw_hit     = w_raw_hit;
  assign o_occupancy   = r_occ;
  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_flush       = r_fsm.flush;
  assign o_flush_cause = r_fsm.cause;
endmodule

// File: tb/tb_write_request_queue.sv
// Scoreboard bench for write_request_queue: directed push/pop/probe sequences, monitor checks pop data.
`timescale 1ns/1ps
module tb_write_request_queue;
  import frontend_command_definition_pkg::*;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic probe_vld;
  logic [ADDR_W-1:0] probe_addr;
  logic raw_hit, full, empty, flush;
  logic [4:0] occ;
  wrq_flush_cause_e cause;

  write_request_queue_if bus();

  int n_chk = 0;
  int n_err = 0;
  int m_occ = 0;
  bit pend_push, pend_pop;
  frontend_command_t sb[$];
  frontend_command_t mon_exp;
  frontend_command_t z = '0;

  always #5 clk = ~clk;

  write_request_queue #(
    .DEPTH_LOG2(4), .HI_WATERMARK(12), .LO_WATERMARK(4), .AGE_LIMIT(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(bus.wr_valid), .o_wr_ready(bus.wr_ready), .i_wr_cmd(bus.wr_cmd),
    .i_rd_probe_valid(probe_vld), .i_rd_probe_addr(probe_addr), .o_raw_hit(raw_hit),
    .o_cmd_valid(bus.cmd_valid), .i_cmd_ready(bus.cmd_ready), .o_cmd(bus.cmd),
    .o_occupancy(occ), .o_full(full), .o_empty(empty),
    .o_flush(flush), .o_flush_cause(cause)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic frontend_command_t mkc(input int n);
    frontend_command_t c;
    c.opcode = 2'b01;
    c.bank   = n[2:0];
    c.row    = 14'(n * 7 + 100);
    c.col    = 10'(n * 3);
    c.tag    = n[7:0];
    return c;
  endfunction

  task automatic drive(input logic wv, input frontend_command_t c, input logic rdy);
    bus.wr_valid  = wv;
    bus.wr_cmd    = c;
    bus.cmd_ready = rdy;
    pend_push = wv && (m_occ < DEPTH);
    pend_pop  = rdy && (m_occ > 0);
    if (pend_push) sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    m_occ = m_occ + int'(pend_push) - int'(pend_pop);
    pend_push = 1'b0;
    pend_pop  = 1'b0;
    #1;
  endtask

  task automatic cyc(input logic wv, input frontend_command_t c, input logic rdy);
    drive(wv, c, rdy);
    tick();
  endtask

  // Monitor: every pop the DUT performs must deliver the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmd_valid", bus.cmd_valid, m_occ != 0);
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          mon_exp = sb.pop_front();
          chk("cmd_data", bus.cmd, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    int seen;
    bus.wr_valid = 1'b0; bus.wr_cmd = '0; bus.cmd_ready = 1'b0;
    probe_vld = 1'b0; probe_addr = '0;
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_occ", occ, 0);
    chk("rst_flush", flush, 0);
    chk("rst_cause", cause, CAUSE_NONE);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Watermark flush with hysteresis
    for (int i = 0; i < 12; i++) cyc(1, mkc(i), 0);
    chk("wm_occ12", occ, 12);
    chk("wm_flush", flush, 1);
    chk("wm_cause", cause, CAUSE_WM);
    for (int i = 0; i < 4; i++) cyc(0, z, 1);
    chk("wm_occ8", occ, 8);
    chk("wm_hyst_hold", flush, 1);
    for (int i = 0; i < 4; i++) cyc(0, z, 1);
    chk("wm_occ4", occ, 4);
    cyc(0, z, 0);
    chk("wm_exit_flush", flush, 0);
    chk("wm_exit_cause", cause, CAUSE_NONE);
    for (int i = 0; i < 4; i++) cyc(0, z, 1);
    cyc(0, z, 0);

    // RAW flush on a stored entry
    for (int i = 0; i < 6; i++) cyc(1, mkc(20 + i), 0);
    drive(0, z, 0);
    probe_vld = 1'b0; probe_addr = cmd_addr(mkc(22));
    #1 chk("raw_probe_invalid", raw_hit, 0);
    probe_vld = 1'b1; probe_addr = cmd_addr(mkc(30));
    #1 chk("raw_miss", raw_hit, 0);
    probe_addr = cmd_addr(mkc(22));
    #1 chk("raw_hit_stored", raw_hit, 1);
    tick();
    probe_vld = 1'b0;
    chk("raw_flush", flush, 1);
    chk("raw_cause", cause, CAUSE_RAW);
    cyc(1, mkc(40), 1);
    cyc(1, mkc(41), 1);
    for (int i = 0; i < 3; i++) cyc(0, z, 1);
    chk("raw_hold_5pops", flush, 1);
    cyc(0, z, 1);
    chk("raw_occ_after6", occ, 2);
    cyc(0, z, 0);
    chk("raw_exit_flush", flush, 0);
    chk("raw_exit_cause", cause, CAUSE_NONE);
    chk("raw_nonempty", empty, 0);
    for (int i = 0; i < 2; i++) cyc(0, z, 1);
    cyc(0, z, 0);

    // RAW hit against the write accepted in the same cycle
    probe_vld = 1'b1; probe_addr = cmd_addr(mkc(50));
    drive(1, mkc(50), 0);
    #1 chk("raw_hit_incoming", raw_hit, 1);
    tick();
    probe_vld = 1'b0;
    chk("raw_in_cause", cause, CAUSE_RAW);
    cyc(0, z, 1);
    cyc(0, z, 0);
    chk("raw_in_exit", flush, 0);

    // Full: no ready pass-through, then mixed traffic across pointer wrap
    for (int i = 0; i < 16; i++) cyc(1, mkc(60 + i), 0);
    chk("full_occ16", occ, 16);
    chk("full_flag", full, 1);
    chk("full_wr_ready", bus.wr_ready, 0);
    probe_vld = 1'b1; probe_addr = cmd_addr(mkc(99));
    drive(1, mkc(99), 0);
    #1 chk("raw_rejected_push", raw_hit, 0);
    probe_vld = 1'b0;
    tick();
    cyc(1, mkc(98), 1);
    chk("full_occ15", occ, 15);
    chk("full_cleared", full, 0);
    for (int i = 0; i < 40; i++) cyc((i % 2) == 0, mkc(100 + i), (i % 3) != 0);
    chk("mixed_occ", occ, m_occ);
    while (m_occ > 0) cyc(0, z, 1);
    cyc(0, z, 0);
    cyc(0, z, 0);
    chk("drain_occ", occ, 0);
    chk("drain_empty", empty, 1);
    chk("drain_flush", flush, 0);

    // Age flush (only with the feature built in)
    cyc(1, mkc(200), 0);
`ifdef WRQ_AGE_FLUSH_EN
    waited = 0;
    while (!flush && waited < 20) begin
      cyc(0, z, 0);
      waited++;
    end
    chk("age_flush", flush, 1);
    chk("age_cause", cause, CAUSE_AGE);
    chk("age_delay_in_range", (waited >= 8) && (waited <= 10), 1);
    cyc(0, z, 1);
    chk("age_exit", flush, 0);
`else
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, z, 0);
      if (flush) seen = 1;
    end
    chk("no_age_flush", seen, 0);
    chk("no_age_cause", cause, CAUSE_NONE);
    cyc(0, z, 1);
`endif
    cyc(0, z, 0);

    // Reset mid RAW flush
    for (int i = 0; i < 5; i++) cyc(1, mkc(210 + i), 0);
    probe_vld = 1'b1; probe_addr = cmd_addr(mkc(212));
    cyc(0, z, 0);
    probe_vld = 1'b0;
    chk("pre_rst_flush", flush, 1);
    chk("pre_rst_cause", cause, CAUSE_RAW);
    #2 rst_n = 1'b0;
    m_occ = 0;
    sb.delete();
    #1;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_cause", cause, CAUSE_NONE);
    chk("mid_rst_occ", occ, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, mkc(220), 0);
    chk("post_rst_occ", occ, 1);
    mon_exp = mkc(220);
    chk("post_rst_head", bus.cmd, mon_exp);
    cyc(0, z, 1);
    cyc(0, z, 0);
    chk("post_rst_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
